// File: rtl/comb_fsm_6s2i2o_mo.sv
// Next-state and Moore-output decode for a six-state FSM (A..F) whose state
// register lives in the parent; illegal encodings 6 and 7 decode to A / 00.
module comb_fsm_6s2i2o_mo (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] state,
    input  logic [1:0] in_,
    output logic [2:0] state_next,
    output logic [1:0] out
);

    typedef enum logic [2:0] {
        ST_A = 3'd0,
        ST_B = 3'd1,
        ST_C = 3'd2,
        ST_D = 3'd3,
        ST_E = 3'd4,
        ST_F = 3'd5
    } state_e;

    state_e state_next_e;

    // clk and reset exist only for port-list parity with sequential siblings
    logic unused_ports;
    assign unused_ports = &{1'b0, clk, reset};

    // Next-state decode
    always_comb begin
        state_next_e = ST_A;
        case (state)
            ST_A: begin
                case (in_)
                    2'b00:   state_next_e = ST_A;
                    2'b01:   state_next_e = ST_B;
                    2'b10:   state_next_e = ST_A;
                    default: state_next_e = ST_E;
                endcase
            end
            ST_B: begin
                case (in_)
                    2'b00:   state_next_e = ST_C;
                    2'b01:   state_next_e = ST_B;
                    2'b10:   state_next_e = ST_A;
                    default: state_next_e = ST_E;
                endcase
            end
            ST_C: begin
                case (in_)
                    2'b00:   state_next_e = ST_A;
                    2'b01:   state_next_e = ST_D;
                    2'b10:   state_next_e = ST_A;
                    default: state_next_e = ST_E;
                endcase
            end
            ST_D: begin
                case (in_)
                    2'b00:   state_next_e = ST_C;
                    2'b01:   state_next_e = ST_B;
                    2'b10:   state_next_e = ST_A;
                    default: state_next_e = ST_E;
                endcase
            end
            ST_E: begin
                case (in_)
                    2'b00:   state_next_e = ST_F;
                    2'b01:   state_next_e = ST_F;
                    2'b10:   state_next_e = ST_A;
                    default: state_next_e = ST_E;
                endcase
            end
            ST_F:    state_next_e = ST_A;
            default: state_next_e = ST_A;
        endcase
    end

    assign state_next = state_next_e;

    // Moore output decode
    always_comb begin
        out = 2'b00;
        case (state)
            ST_A:    out = 2'b00;
            ST_B:    out = 2'b00;
            ST_C:    out = 2'b00;
            ST_D:    out = 2'b01;
            ST_E:    out = 2'b10;
            ST_F:    out = 2'b10;
            default: out = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_comb_fsm_6s2i2o_mo.sv
// Bench for comb_fsm_6s2i2o_mo: exhaustive sweep, random vectors and
// clk/reset independence, all checked against a rule-based model.
module tb_comb_fsm_6s2i2o_mo;

    logic       clk;
    logic       reset;
    logic [2:0] state;
    logic [1:0] in_;
    logic [2:0] state_next;
    logic [1:0] out;

    int unsigned checks;
    int unsigned errors;

    comb_fsm_6s2i2o_mo dut (
        .clk        (clk),
        .reset      (reset),
        .state      (state),
        .in_        (in_),
        .state_next (state_next),
        .out        (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model built from the summary rules rather than the full table
    function automatic logic [2:0] model_next(input int s, input int i);
        if (s > 5)   return 3'd0;
        if (i == 2)  return 3'd0;
        if (s == 5)  return 3'd0;
        if (i == 3)  return 3'd4;
        if (s == 4)  return 3'd5;
        if (i == 1)  return (s == 2) ? 3'd3 : 3'd1;
        return (s == 1 || s == 3) ? 3'd2 : 3'd0;
    endfunction

    function automatic logic [1:0] model_out(input int s);
        if (s == 3)           return 2'b01;
        if (s == 4 || s == 5) return 2'b10;
        return 2'b00;
    endfunction

    task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic apply_and_check(input int s, input int i, input string tag);
        state = 3'(s);
        in_   = 2'(i);
        #1;
        check3($sformatf("%s_next s=%0d i=%0d", tag, s, i), state_next, model_next(s, i));
        check2($sformatf("%s_out s=%0d i=%0d", tag, s, i), out, model_out(s));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        state  = 3'd0;
        in_    = 2'd0;

        @(negedge clk);
        reset = 1'b1;

        // Spot checks from hand-derived values, independent of the model
        state = 3'd0; in_ = 2'b01; #1;
        check3("ex_a_01", state_next, 3'd1);
        check2("ex_a_out", out, 2'b00);
        state = 3'd2; in_ = 2'b01; #1;
        check3("ex_c_01", state_next, 3'd3);
        state = 3'd3; in_ = 2'b00; #1;
        check3("ex_d_00", state_next, 3'd2);
        check2("ex_d_out", out, 2'b01);
        state = 3'd4; in_ = 2'b00; #1;
        check3("ex_e_00", state_next, 3'd5);
        check2("ex_e_out", out, 2'b10);
        state = 3'd4; in_ = 2'b11; #1;
        check3("ex_e_11", state_next, 3'd4);
        state = 3'd5; in_ = 2'b01; #1;
        check3("ex_f_01", state_next, 3'd0);
        check2("ex_f_out", out, 2'b10);
        state = 3'd7; in_ = 2'b11; #1;
        check3("ex_ill7_11", state_next, 3'd0);
        check2("ex_ill7_out", out, 2'b00);

        // Exhaustive sweep incl. illegal encodings 6 and 7
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 4; i++) begin
                apply_and_check(s, i, "sweep");
            end
        end

        // Random vectors
        for (int n = 0; n < 200; n++) begin
            apply_and_check(int'($urandom_range(7, 0)), int'($urandom_range(3, 0)), "rand");
        end

        // clk/reset independence while holding D with in_=01
        state = 3'd3;
        in_   = 2'b01;
        for (int n = 0; n < 6; n++) begin
            reset = n[0];
            @(posedge clk);
            #1;
            check3($sformatf("hold_next n=%0d", n), state_next, 3'd1);
            check2($sformatf("hold_out n=%0d", n), out, 2'b01);
            @(negedge clk);
            #1;
            check3($sformatf("hold_next_neg n=%0d", n), state_next, 3'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comb_fsm_6s2i2o_mo.md
# comb_fsm_6s2i2o_mo

Combinational next-state and output logic for a six-state Moore FSM with a 2-bit input and a 2-bit output. The block holds no state: the parent module owns the 3-bit state register, feeds the current state in, and loads `state_next` on each clock edge. It gives the parent a single, exhaustively specified decode of the state diagram, including defined behaviour for the two unused encodings.

## Interface
- Parameters: none.
- `clk`  input  1  system clock. The combinational datapath does not use it; it keeps the port list uniform with sequential siblings.
- `reset`  input  1  reset, synchronous and active-low. The combinational datapath does not use it; the parent applies it to its own state register.
- `state`  input  3  current state encoding: A=0, B=1, C=2, D=3, E=4, F=5. Values 6 and 7 are illegal.
- `in_`  input  2  FSM input.
- `state_next`  output  3  next-state encoding, same code as `state`.
- `out`  output  2  Moore output; a function of `state` only.

## Operation
Moore outputs:
- A=00, B=00, C=00, D=01, E=10, F=10.

Transitions, listed in the order in_=00 / 01 / 10 / 11:
- A → A / B / A / E
- B → C / B / A / E
- C → A / D / A / E
- D → C / B / A / E
- E → F / F / A / E
- F → A / A / A / A

Rules that summarise the table:
- in_=10 always goes to A.
- in_=11 goes to E from every state except F.
- F is a one-visit state and always returns to A.

Illegal states (6, 7):
- `state_next`=0 and `out`=00 for every `in_`.
- No X propagation: every case branch and the default assign both outputs.

General:
- The logic is fully combinational: no latches and no internal registers.
- Every input combination produces a defined output.
- The parent's register resets to A (0) when `reset`=0 at a `clk` edge. This block does not implement that register.

## Timing
- Zero-cycle latency: `state_next` and `out` settle within the same cycle as any change on `state` or `in_`.
- No reset value applies to the outputs; they track the inputs continuously, including while `reset` is asserted.
- `clk` and `reset` have no effect on either output.
- Each output must be stable a setup time before the parent's next rising `clk`.

## Test plan
- Sweep every legal state (0–5) against every `in_` (00–11), 24 vectors, and check both outputs against the tables. Examples:
  - state=0, in_=01 → state_next=1, out=00
  - state=2, in_=01 → state_next=3, out=00
  - state=3, in_=00 → state_next=2, out=01
- E behaviour:
  - state=4, in_=00 → state_next=5, out=10
  - state=4, in_=11 → state_next=4, out=10
- F always exits to A:
  - state=5 with in_=00, 01, 10, 11 → state_next=0 each time, out=10
- Forced return to A:
  - in_=10 from every legal state → state_next=0
  - in_=11 from states 0–4 → state_next=4
- Illegal encodings:
  - state=6 and state=7, each with all four `in_` values → state_next=0, out=00, no X on either output.
- Reset and clock independence: toggle `reset` low and high, and run `clk`, while holding state=3, in_=01 → state_next=1, out=01 throughout.
